// File: rtl/cypress_fifo_reader.sv
// -----------------------------------------------------------------------------
// cypress_fifo_reader
//
// Reads 16-bit words from a Cypress slave FIFO and feeds them to the SPI output
// serializer. The block watches the FIFO empty flag and issues single-cycle
// SLRD strobes. The serializer samples FD on SLRD. A new word is never strobed
// while the serializer is still shifting out the previous one.
//
// Ports:
//   SYS_CLK       in   system clock
//   RST           in   asynchronous reset, active-low
//   ENABLE        in   1 = reads permitted (level, sampled every cycle)
//   FLAG_EMPTY_N  in   Cypress EF flag, active-low, asynchronous (2-flop synced)
//   BUSY          in   serializer busy from the RX_CLK domain (2-flop synced)
//   FIFOADR[1:0]  out  endpoint select, constant EP_ADDR
//   SLOE          out  FIFO output enable, active-high
//   SLRD          out  one-cycle read strobe, active-high (drives serializer ENA)
//   WORD_CNT[15:0]out  number of SLRD strobes since reset, wraps naturally
//   ACTIVE        out  1 whenever the read FSM is not idle
//
// GAP_CYCLES must be >= 3. It covers the serializer's RX_CLK capture of SLRD
// plus the BUSY synchroniser latency, so a fresh BUSY is visible before WAIT.
// -----------------------------------------------------------------------------
module cypress_fifo_reader #(
  parameter logic [1:0] EP_ADDR    = 2'b00,
  parameter int         OE_SETUP   = 2,
  parameter int         GAP_CYCLES = 6
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        FLAG_EMPTY_N,
  input  logic        BUSY,
  output logic [1:0]  FIFOADR,
  output logic        SLOE,
  output logic        SLRD,
  output logic [15:0] WORD_CNT,
  output logic        ACTIVE
);

  // One down-counter serves both SETUP and GAP, so it is sized for the larger.
  localparam int CNT_MAX = (OE_SETUP > GAP_CYCLES) ? OE_SETUP : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_GAP,
    S_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic               sloe_q, sloe_d;
  logic               slrd_q, slrd_d;
  logic               active_q, active_d;

  // Synchroniser chains. Their reset values are the safe ones: the FIFO is
  // treated as empty and the serializer as busy until real values arrive.
  logic               empty_meta_q, empty_s_q;
  logic               busy_meta_q, busy_s_q;

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      empty_meta_q <= 1'b0;
      empty_s_q    <= 1'b0;
      busy_meta_q  <= 1'b1;
      busy_s_q     <= 1'b1;
    end else begin
      empty_meta_q <= FLAG_EMPTY_N;
      empty_s_q    <= empty_meta_q;
      busy_meta_q  <= BUSY;
      busy_s_q     <= busy_meta_q;
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_cnt_d = word_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ENABLE && empty_s_q && !busy_s_q) begin
          state_d = S_SETUP;
          cnt_d   = CNT_W'(OE_SETUP - 1);
        end
      end

      S_SETUP: begin
        // The FIFO emptying during bus turnaround aborts before any strobe.
        if (!empty_s_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_READ: begin
        state_d = S_GAP;
        cnt_d   = CNT_W'(GAP_CYCLES - 1);
      end

      S_GAP: begin
        // BUSY is not yet trustworthy here: the serializer's response to the
        // last strobe may still be in the synchroniser.
        if (cnt_q == '0) begin
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WAIT: begin
        if (!busy_s_q) begin
          // Within a burst the bus is already turned around, so SETUP is skipped.
          state_d = (ENABLE && empty_s_q) ? S_READ : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they belong to.
    if (state_d == S_READ) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
    sloe_d   = (state_d != S_IDLE);
    slrd_d   = (state_d == S_READ);
    active_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_cnt_q <= 16'h0000;
      sloe_q     <= 1'b0;
      slrd_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_cnt_q <= word_cnt_d;
      sloe_q     <= sloe_d;
      slrd_q     <= slrd_d;
      active_q   <= active_d;
    end
  end

  assign FIFOADR  = EP_ADDR;
  assign SLOE     = sloe_q;
  assign SLRD     = slrd_q;
  assign WORD_CNT = word_cnt_q;
  assign ACTIVE   = active_q;

endmodule

// File: tb/tb_cypress_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_cypress_fifo_reader
//
// Directed bench for cypress_fifo_reader: reset state, single-word latency,
// paced bursts against a serializer BUSY model, empty flag and ENABLE
// withdrawal mid-burst, stuck BUSY, reset mid-burst and WORD_CNT wrap.
// -----------------------------------------------------------------------------
module tb_cypress_fifo_reader;

  localparam int BUSY_LEN = 16;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flag_empty_n;
  logic        busy_drv;
  logic        busy_model;
  logic        busy;
  logic [1:0]  fifoadr;
  logic        sloe;
  logic        slrd;
  logic [15:0] word_cnt;
  logic        active;

  logic        model_en;
  logic        slrd_prev;

  int          n_checks = 0;
  int          n_fails  = 0;

  assign busy = busy_drv | busy_model;

  cypress_fifo_reader #(
    .EP_ADDR    (2'b00),
    .OE_SETUP   (2),
    .GAP_CYCLES (6)
  ) dut (
    .SYS_CLK      (sys_clk),
    .RST          (rst),
    .ENABLE       (enable),
    .FLAG_EMPTY_N (flag_empty_n),
    .BUSY         (busy),
    .FIFOADR      (fifoadr),
    .SLOE         (sloe),
    .SLRD         (slrd),
    .WORD_CNT     (word_cnt),
    .ACTIVE       (active)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Waits up to max_cycles for an SLRD strobe; reports cycles waited and
  // whether SLOE was ever low on the way.
  task automatic wait_slrd(input int max_cycles, output bit found, output int n,
                           output bit sloe_low);
    found    = 1'b0;
    sloe_low = 1'b0;
    n        = 0;
    while (n < max_cycles && !found) begin
      tick();
      n++;
      if (slrd) found = 1'b1;
      else if (!sloe) sloe_low = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    flag_empty_n = 1'b0;
    busy_drv     = 1'b0;
    model_en     = 1'b0;
    enable       = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Serializer model: BUSY rises 2 cycles after SLRD and holds BUSY_LEN cycles.
  initial begin
    busy_model = 1'b0;
    forever begin
      tick();
      if (model_en && slrd) begin
        repeat (2) tick();
        busy_model = 1'b1;
        repeat (BUSY_LEN) tick();
        busy_model = 1'b0;
      end
    end
  end

  // Every strobe must come with SLOE high and must be a single cycle.
  initial slrd_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (rst && slrd) begin
      check("slrd_with_sloe", {31'd0, sloe}, 32'd1);
      check("slrd_single_cycle", {31'd0, slrd_prev}, 32'd0);
    end
    slrd_prev = slrd;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit sloe_low;
    int n;
    bit any_slrd;

    rst          = 1'b0;
    enable       = 1'b0;
    flag_empty_n = 1'b0;
    busy_drv     = 1'b0;
    model_en     = 1'b0;
    repeat (3) tick();
    check("rst_sloe",     {31'd0, sloe},   32'd0);
    check("rst_slrd",     {31'd0, slrd},   32'd0);
    check("rst_fifoadr",  {30'd0, fifoadr}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("rst_active",   {31'd0, active}, 32'd0);

    // Release with the FIFO empty: nothing may happen.
    rst    = 1'b1;
    enable = 1'b1;
    any_slrd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (slrd || sloe) any_slrd = 1'b1;
    end
    check("idle_no_activity", {31'd0, any_slrd}, 32'd0);
    check("idle_word_cnt",    {16'd0, word_cnt}, 32'd0);

    // Single word: SLOE at t+3, SLRD at t+5 for one cycle.
    flag_empty_n = 1'b1;
    tick(); tick();
    check("single_sloe_t2", {31'd0, sloe}, 32'd0);
    tick();
    check("single_sloe_t3",   {31'd0, sloe},   32'd1);
    check("single_active_t3", {31'd0, active}, 32'd1);
    tick();
    check("single_slrd_t4", {31'd0, slrd}, 32'd0);
    tick();
    check("single_slrd_t5",  {31'd0, slrd},     32'd1);
    check("single_word_cnt", {16'd0, word_cnt}, 32'd1);
    flag_empty_n = 1'b0;
    tick();
    check("single_slrd_t6", {31'd0, slrd}, 32'd0);
    wait_slrd(20, found, n, sloe_low);
    check("single_no_second", {31'd0, found},  32'd0);
    check("single_idle",      {31'd0, active}, 32'd0);
    check("single_sloe_off",  {31'd0, sloe},   32'd0);

    // Burst of 8 paced by the serializer model.
    do_reset();
    model_en     = 1'b1;
    flag_empty_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_slrd(100, found, n, sloe_low);
      check("burst_strobe_found", {31'd0, found}, 32'd1);
      if (k > 0) begin
        check("burst_spacing",  {31'd0, n >= BUSY_LEN + 2}, 32'd1);
        check("burst_no_setup", {31'd0, sloe_low}, 32'd0);
      end
      if (k == 7) flag_empty_n = 1'b0;
    end
    check("burst_word_cnt", {16'd0, word_cnt}, 32'd8);
    wait_slrd(60, found, n, sloe_low);
    check("burst_no_ninth", {31'd0, found},  32'd0);
    check("burst_idle",     {31'd0, active}, 32'd0);
    check("burst_sloe_off", {31'd0, sloe},   32'd0);
    model_en = 1'b0;

    // FIFO goes empty after the 3rd strobe.
    do_reset();
    model_en     = 1'b1;
    flag_empty_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_slrd(100, found, n, sloe_low);
      check("empty_strobe_found", {31'd0, found}, 32'd1);
    end
    flag_empty_n = 1'b0;
    repeat (10) tick();
    check("empty_sloe_while_busy", {31'd0, sloe}, 32'd1);
    wait_slrd(60, found, n, sloe_low);
    check("empty_no_fourth", {31'd0, found},    32'd0);
    check("empty_idle",      {31'd0, active},   32'd0);
    check("empty_sloe_off",  {31'd0, sloe},     32'd0);
    check("empty_word_cnt",  {16'd0, word_cnt}, 32'd3);
    model_en = 1'b0;

    // ENABLE withdrawn during GAP.
    do_reset();
    flag_empty_n = 1'b1;
    wait_slrd(20, found, n, sloe_low);
    check("en_first_found", {31'd0, found}, 32'd1);
    tick(); tick();
    enable = 1'b0;
    wait_slrd(40, found, n, sloe_low);
    check("en_no_second", {31'd0, found},    32'd0);
    check("en_idle",      {31'd0, active},   32'd0);
    check("en_word_cnt",  {16'd0, word_cnt}, 32'd1);

    // BUSY stuck high for 1000 cycles.
    do_reset();
    flag_empty_n = 1'b1;
    wait_slrd(20, found, n, sloe_low);
    check("stuck_first_found", {31'd0, found}, 32'd1);
    busy_drv = 1'b1;
    wait_slrd(1000, found, n, sloe_low);
    check("stuck_no_strobe", {31'd0, found},    32'd0);
    check("stuck_sloe_held", {31'd0, sloe_low}, 32'd0);
    check("stuck_active",    {31'd0, active},   32'd1);
    check("stuck_slrd_low",  {31'd0, slrd},     32'd0);
    busy_drv = 1'b0;
    wait_slrd(10, found, n, sloe_low);
    check("stuck_resume",   {31'd0, found},    32'd1);
    check("stuck_word_cnt", {16'd0, word_cnt}, 32'd2);

    // Reset asserted during GAP takes effect without a clock edge.
    do_reset();
    flag_empty_n = 1'b1;
    wait_slrd(20, found, n, sloe_low);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rstgap_sloe",     {31'd0, sloe},     32'd0);
    check("rstgap_slrd",     {31'd0, slrd},     32'd0);
    check("rstgap_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("rstgap_active",   {31'd0, active},   32'd0);

    // Reset asserted while SLRD is high cuts the strobe.
    do_reset();
    flag_empty_n = 1'b1;
    wait_slrd(20, found, n, sloe_low);
    check("rstrd_found", {31'd0, found}, 32'd1);
    rst = 1'b0;
    #1;
    check("rstrd_slrd_cut", {31'd0, slrd},     32'd0);
    check("rstrd_word_cnt", {16'd0, word_cnt}, 32'd0);

    // WORD_CNT wrap: preload near the top, then issue two strobes.
    do_reset();
    force dut.word_cnt_q = 16'hFFFE;
    tick();
    release dut.word_cnt_q;
    flag_empty_n = 1'b1;
    wait_slrd(20, found, n, sloe_low);
    check("wrap_ffff", {16'd0, word_cnt}, 32'h0000FFFF);
    wait_slrd(20, found, n, sloe_low);
    check("wrap_zero", {16'd0, word_cnt}, 32'h00000000);
    flag_empty_n = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
